// File: rtl/alu_iter.sv
// alu_iter: width-parametrised multi-cycle ALU (sum/logic/shift single-cycle, shift-add mul, restoring div).
// Latency: start edge to registered done pulse is N+2 cycles (N=1, or WIDTH for mul/div); start ignored while busy.
// Build option ALU_ITER_DIV_EN: defined builds the divider; undefined makes cselect 6 a 1-cycle op returning 0.
module alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [10:0]      ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             carry_en,
  input  logic             flags_en,
  input  logic             oe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             dbz
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   ITER_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, EXEC, POST} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, x_q, y_q;
  logic [WIDTH-1:0] hi_q;   // mul: product high half; div: partial remainder
  logic [WIDTH-1:0] lo_q;   // mul: multiplier/product low half; div: dividend/quotient; else raw result
  logic [WIDTH-1:0] res_q;
  logic [10:0]      ctrl_q;
  logic             cin_q, cout_q;
  logic [SHW-1:0]   cnt;

  logic [2:0]       csel;
  logic             is_mul, is_div, iter_op, big_shift;
  logic [WIDTH-1:0] x_n, y_n, single_res, fin;
  logic [WIDTH:0]   sum_w, mul_add;
  // ctrl[6] selected the high half in the 16-bit predecessor; result_hi makes it redundant.
  logic             ctrl_high_unused;

  assign ctrl_high_unused = ctrl_q[6];
  assign csel    = ctrl_q[10:8];
  assign is_mul  = (csel == 3'd5);
`ifdef ALU_ITER_DIV_EN
  assign is_div  = (csel == 3'd6);
`else
  assign is_div  = 1'b0;
`endif
  assign iter_op = is_mul | is_div;
  assign result  = oe ? res_q : '0;

  // Operand conditioning, single-cycle results and the multiply step adder.
  always_comb begin
    x_n       = (ctrl_q[0] ? '0 : a_q) ^ {WIDTH{ctrl_q[1]}};
    y_n       = (ctrl_q[2] ? '0 : b_q) ^ {WIDTH{ctrl_q[3]}};
    sum_w     = {1'b0, x_q} + {1'b0, y_q} + (WIDTH+1)'(ctrl_q[5])
              + (WIDTH+1)'(carry_en & ctrl_q[7] & cin_q);
    big_shift = (y_q >= SHIFT_LIM);
    mul_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
    fin       = lo_q ^ {WIDTH{ctrl_q[4]}};
    case (csel)
      3'd0:    single_res = sum_w[WIDTH-1:0];
      3'd1:    single_res = x_q & y_q;
      3'd2:    single_res = x_q ^ y_q;
      3'd3:    single_res = big_shift ? '0 : (x_q << y_q[SHW-1:0]);
      3'd4:    single_res = big_shift ? '0 : (x_q >> y_q[SHW-1:0]);
      3'd7:    single_res = big_shift ? {WIDTH{x_q[MSB]}} : WIDTH'($signed(x_q) >>> y_q[SHW-1:0]);
      default: single_res = '0;
    endcase
  end

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;

  // Restoring divide step: shift in the next dividend bit, subtract divisor if it fits.
  always_comb begin
    div_sh      = {hi_q, lo_q[MSB]};
    div_ge      = (div_sh >= {1'b0, y_q});
    div_rem_nxt = WIDTH'(div_ge ? (div_sh - {1'b0, y_q}) : div_sh);
  end
`endif

  // Control FSM and datapath registers; outputs and flags are registered at POST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      result_hi <= '0;
      ctrl_q    <= '0;
      cin_q     <= 1'b0;
      cout_q    <= 1'b0;
      cnt       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            ctrl_q <= ctrl;
            cin_q  <= carry_in;
            busy   <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          x_q   <= x_n;
          y_q   <= y_n;
          hi_q  <= '0;
          lo_q  <= is_div ? x_n : y_n;
          cnt   <= iter_op ? ITER_LAST : '0;
          state <= EXEC;
        end
        EXEC: begin
          if (is_mul) begin
            {hi_q, lo_q} <= {mul_add, lo_q[WIDTH-1:1]};
          end
`ifdef ALU_ITER_DIV_EN
          else if (is_div) begin
            hi_q <= div_rem_nxt;
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
          end
`endif
          else begin
            lo_q   <= single_res;
            cout_q <= sum_w[WIDTH];
          end
          if (cnt == '0) state <= POST;
          else           cnt   <= cnt - 1'b1;
        end
        POST: begin
          res_q     <= fin;
          result_hi <= iter_op ? hi_q : '0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
          if (flags_en) begin
            zero      <= (fin == '0);
            negative  <= fin[MSB];
            carry_out <= (csel == 3'd0) &
                         ((((ctrl_q[1] | ctrl_q[3]) & ctrl_q[5])) ? ~cout_q : cout_q);
            overflow  <= (csel == 3'd0) &
                         ((~lo_q[MSB] & x_q[MSB] & y_q[MSB]) | (lo_q[MSB] & ~x_q[MSB] & ~y_q[MSB]));
            dbz       <= is_div & (y_q == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed spec examples plus randomized ops against an arithmetic reference model.
// Checks latency, result/result_hi gating, sticky flags, ignored start while busy, reset abort, back-to-back start.
// Build with or without ALU_ITER_DIV_EN; the model follows the same macro.
module tb_alu_iter;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, start, carry_in, carry_en, flags_en, oe;
  logic [10:0]   ctrl;
  logic [W-1:0]  a, b;
  logic          busy, done, carry_out, overflow, zero, negative, dbz;
  logic [W-1:0]  result, result_hi;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .carry_in(carry_in), .carry_en(carry_en), .flags_en(flags_en), .oe(oe),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state: expected outputs of the op in flight and the sticky flag values
  logic [W-1:0] exp_res, exp_hi;
  logic         exp_oe;
  int           exp_lat, last_lat;
  logic         m_co, m_ov, m_z, m_n, m_dbz;
  string        cur;

  logic [W-1:0] ra, rb;
  logic [10:0]  rc;
  logic [2:0]   rcs;
  int           done_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Computes the expected outcome from the operation definitions, then drives the request.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [10:0] tc,
                        input logic tcin, input logic tcen, input logic tfen, input logic toe);
    logic [W-1:0] x, y, r;
    logic [W:0]   s;
    logic [31:0]  p;
    logic         io, po, cout, e_co, e_ov, e_dbz;
    int           n;
    x = tc[0] ? '0 : ta;
    if (tc[1]) x = ~x;
    y = tc[2] ? '0 : tb_v;
    if (tc[3]) y = ~y;
    io = tc[4];
    po = tc[5];
    r = '0; exp_hi = '0; n = 1;
    e_co = 1'b0; e_ov = 1'b0; e_dbz = 1'b0;
    case (tc[10:8])
      3'd0: begin
        s = (W+1)'(x) + (W+1)'(y) + (W+1)'(po) + (W+1)'(tcen & tc[7] & tcin);
        r = s[W-1:0];
        cout = s[W];
        e_co = ((tc[1] | tc[3]) & po) ? ~cout : cout;
        e_ov = (~r[W-1] & x[W-1] & y[W-1]) | (r[W-1] & ~x[W-1] & ~y[W-1]);
      end
      3'd1: r = x & y;
      3'd2: r = x ^ y;
      3'd3: r = (y >= W) ? '0 : W'(int'(x) * (2 ** int'(y)));
      3'd4: r = (y >= W) ? '0 : W'(int'(x) / (2 ** int'(y)));
      3'd5: begin
        p = 32'(x) * 32'(y);
        r = p[15:0];
        exp_hi = p[31:16];
        n = W;
      end
      3'd6: begin
`ifdef ALU_ITER_DIV_EN
        n = W;
        if (y == 0) begin
          r = '1; exp_hi = x; e_dbz = 1'b1;
        end else begin
          r = x / y; exp_hi = x % y;
        end
`else
        r = '0;
`endif
      end
      default: r = (y >= W) ? {W{x[W-1]}} : W'($signed(x) >>> y);
    endcase
    exp_res = r ^ {W{io}};
    if (tfen) begin
      m_co = e_co; m_ov = e_ov; m_z = (exp_res == 0); m_n = exp_res[W-1]; m_dbz = e_dbz;
    end
    exp_oe  = toe;
    exp_lat = n + 2;
    a = ta; b = tb_v; ctrl = tc; carry_in = tcin; carry_en = tcen; flags_en = tfen; oe = toe;
    start = 1'b1;
  endtask

  // Called right after launch (#1 after a posedge); waits for done and checks everything.
  task automatic finish_op(input bit chk_width, input bit inject);
    int cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({cur, "_busy"}, busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (inject && cyc == 4) begin
        start = 1'b1; a = ~a; b = 16'h0003;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    last_lat = cyc;
    check_val({cur, "_lat"}, cyc, exp_lat);
    check_val({cur, "_res"}, result, exp_oe ? exp_res : '0);
    check_val({cur, "_hi"}, result_hi, exp_hi);
    check_val({cur, "_cout"}, carry_out, m_co);
    check_val({cur, "_ovf"}, overflow, m_ov);
    check_val({cur, "_zero"}, zero, m_z);
    check_val({cur, "_neg"}, negative, m_n);
    check_val({cur, "_dbz"}, dbz, m_dbz);
    if (chk_width) begin
      @(posedge clk); #1;
      check_val({cur, "_donew"}, done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
    carry_in = 1'b0; carry_en = 1'b0; flags_en = 1'b1; oe = 1'b1;
    m_co = 0; m_ov = 0; m_z = 0; m_n = 0; m_dbz = 0;
    #12;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_res", result, 0);
    check_val("rst_hi", result_hi, 0);
    check_val("rst_flags", {carry_out, overflow, zero, negative, dbz}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    cur = "add"; launch(16'h7FFF, 16'h0001, 11'h000, 0, 0, 1, 1); finish_op(1, 0);
    check_val("add_lit", {result, overflow, negative, carry_out}, {16'h8000, 3'b110});
    check_val("add_lat_lit", last_lat, 3);
    cur = "sub"; launch(16'd5, 16'd7, 11'h028, 0, 0, 1, 1); finish_op(1, 0);
    check_val("sub_lit", {result, carry_out, negative}, {16'hFFFE, 2'b11});
    cur = "mul"; launch(16'h1234, 16'h0100, 11'h500, 0, 0, 1, 1); finish_op(1, 0);
    check_val("mul_lit", {result, result_hi}, {16'h3400, 16'h0012});
    check_val("mul_lat_lit", last_lat, 18);
    cur = "div"; launch(16'd100, 16'd7, 11'h600, 0, 0, 1, 1); finish_op(1, 0);
`ifdef ALU_ITER_DIV_EN
    check_val("div_lit", {result, result_hi}, {16'd14, 16'd2});
`else
    check_val("div_lit", {result, 6'(last_lat)}, {16'd0, 6'd3});
`endif
    cur = "div0"; launch(16'd100, 16'd0, 11'h600, 0, 0, 1, 1); finish_op(1, 0);
`ifdef ALU_ITER_DIV_EN
    check_val("div0_lit", {result, result_hi, dbz}, {16'hFFFF, 16'd100, 1'b1});
`endif
    cur = "asr"; launch(16'h8000, 16'd20, 11'h700, 0, 0, 1, 1); finish_op(1, 0);
    check_val("asr_lit", result, 16'hFFFF);
    cur = "shl"; launch(16'hABCD, 16'd16, 11'h300, 0, 0, 1, 1); finish_op(1, 0);
    check_val("shl_lit", result, 16'h0000);

    // carry chain, sticky flags with flags_en=0, oe gating
    cur = "addc"; launch(16'hFFFF, 16'h0000, 11'h080, 1, 1, 1, 1); finish_op(1, 0);
    cur = "zero"; launch(16'h0000, 16'h0000, 11'h000, 0, 0, 1, 1); finish_op(1, 0);
    cur = "nofl"; launch(16'h8001, 16'h8001, 11'h000, 0, 0, 0, 1); finish_op(1, 0);
    cur = "oe0"; launch(16'h0F0F, 16'h0303, 11'h500, 0, 0, 1, 0); finish_op(1, 0);

    // start during busy is ignored
    cur = "inj"; launch(16'h00FF, 16'h0101, 11'h500, 0, 0, 1, 1); finish_op(1, 1);

    // back-to-back: second start in the done cycle
    cur = "b2b1"; launch(16'd10, 16'd20, 11'h000, 0, 0, 1, 1); finish_op(0, 0);
    cur = "b2b2"; launch(16'h00F0, 16'h0FF0, 11'h100, 0, 0, 1, 1); finish_op(1, 0);

    // reset mid-multiply aborts without a done pulse
    cur = "rstop"; launch(16'h1234, 16'h5678, 11'h500, 0, 0, 1, 1);
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("rstop_busy", busy, 0);
    check_val("rstop_res", {result, result_hi}, 0);
    check_val("rstop_flags", {carry_out, overflow, zero, negative, dbz}, 0);
    m_co = 0; m_ov = 0; m_z = 0; m_n = 0; m_dbz = 0;
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check_val("rstop_nodone", done_seen, 0);

    // randomized operations
    for (int i = 0; i < 200; i++) begin
      rcs = 3'($urandom_range(0, 7));
      rc = 11'($urandom);
      rc[10:8] = rcs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ((rcs == 3'd3 || rcs == 3'd4 || rcs == 3'd7) && $urandom_range(0, 1) == 1) begin
        rb = 16'($urandom_range(0, 20));
        rc[3:2] = 2'b00;
      end
      if (rcs == 3'd6) begin
        rc[4] = 1'b0;
        if ($urandom_range(0, 3) == 0) rb = '0;
        else if ($urandom_range(0, 1) == 1) rb = 16'($urandom_range(1, 300));
      end
      cur = $sformatf("rnd%0d", i);
      launch(ra, rb, rc, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      finish_op(1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
